dm_access_ctrl: RTL and testbench
=================================

# dm_access_ctrl

Clocked initiator for the 16-bit asynchronous data memory (`datamem`) port. It accepts single or burst load/store requests from the core over valid/ready handshakes. It sequences `we_DM`/`addrDM`/`dataDM` with explicit setup, strobe and hold cycles, then returns read data or a write acknowledge. It sits between the core's execute stage and `datamem` and is the only driver of the data-memory port.

## Interface
- `MEM_DEPTH`, 1024: number of valid words; addresses `>= MEM_DEPTH` are out of range.
- `RD_WAIT`, 1: cycles `addrDM` is held stable with `we_DM=0` before `outDM` is sampled (1..7).
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = store burst, 0 = load burst.
- `req_addr` in 16: first word address.
- `req_len` in 4: beat count minus one (0 → 1 beat, 15 → 16 beats).
- `wd_valid` in 1: store data beat present.
- `wd_ready` out 1: store data beat accepted this cycle.
- `wd_data` in 16: store data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: core accepts response.
- `rsp_data` out 16: load data (0 for store ack or error).
- `rsp_err` out 1: range error on this response.
- `rsp_last` out 1: final response of the burst.
- `busy` out 1: high in every state except IDLE.
- `we_DM` out 1: memory write strobe to `datamem`.
- `addrDM` out 16: memory address to `datamem`.
- `dataDM` out 16: memory write data to `datamem`.
- `outDM` in 16: memory read data from `datamem`.

## Operation
- States:
  - IDLE: `req_ready=1`. On `req_valid`, latch addr, len and we. If `addr + len > MEM_DEPTH-1` (17-bit compare, no wrap), go to ERR. Otherwise go to W_SETUP for a store or R_SETUP for a load.
  - ERR: `rsp_valid=1`, `rsp_err=1`, `rsp_last=1`, `rsp_data=0`. No memory access; `we_DM` never rises. Return to IDLE on `rsp_ready`.
  - W_SETUP: `wd_ready=1`, `we_DM=0`, `addrDM=cur`. On `wd_valid`, register `dataDM=wd_data` and go to W_STROBE.
  - W_STROBE: `we_DM=1` for exactly one cycle; addr and data unchanged. Next state W_HOLD.
  - W_HOLD: `we_DM=0`; addr and data unchanged. If more beats remain, `cur+1` and go to W_SETUP. Otherwise go to W_ACK.
  - W_ACK: `rsp_valid=1`, `rsp_last=1`, `rsp_data=0`. Store bursts return a single ack. Return to IDLE on `rsp_ready`.
  - R_SETUP: `we_DM=0`, `addrDM=cur`; wait counter loads `RD_WAIT`. Decrement each cycle; at 0, register `rsp_data=outDM` and go to R_RESP.
  - R_RESP: `rsp_valid=1`; `rsp_last=1` on the final beat. On `rsp_ready`, take the next beat (`cur+1`, go to R_SETUP) or return to IDLE.
- `addrDM`/`dataDM` hold their last value in IDLE. No glitch on `we_DM`: it is a registered output.
- Address increments +1 per beat. It never wraps because the range check runs up front.
- `rsp_*` stay stable while `rsp_valid && !rsp_ready`.
- `wd_valid` outside W_SETUP is ignored, with `wd_ready=0`.

## Timing
- Reset values: `req_ready=0` during reset and 1 in the first cycle after; `wd_ready`, `rsp_valid`, `rsp_err`, `rsp_last`, `busy`, `we_DM` = 0; `addrDM`, `dataDM`, `rsp_data` = 0. State goes to IDLE.
- Reset mid-operation: the next edge forces IDLE. `we_DM=0` in the cycle after `rst_n` is sampled low, and the burst is dropped with no response.
- Single store, `wd_valid` already high, `rsp_ready=1`:
  - Request accepted at edge 0.
  - W_SETUP in cycle 1; `we_DM` high in cycle 2.
  - `rsp_valid` in cycle 4.
  - IDLE in cycle 5.
- Single load: `rsp_valid` in cycle `2+RD_WAIT`.
- Store burst throughput: 3 cycles per beat with no `wd_valid` stalls. Load burst: `RD_WAIT+2` cycles per beat with `rsp_ready=1`.
- `req_valid` and a response handshake cannot coincide: `req_ready=0` whenever `busy=1`.

## Structure
- Package `dm_pkg`:
  - State enum `dm_state_t`: IDLE, ERR, W_SETUP, W_STROBE, W_HOLD, W_ACK, R_SETUP, R_RESP.
  - `DM_AW=16`, `DM_DW=16`, `DM_LENW=4`.
  - Default `MEM_DEPTH`.
- One sub-module, `dm_beat_ctr`: holds the current address, remaining-beats counter, last-beat flag and RD_WAIT down-counter.
- The FSM stays in `dm_access_ctrl`.

## Test plan
- Store addr 0x0000 with data 0x1dfe, then load addr 0x0000 (RD_WAIT=1) → `we_DM` high exactly 1 cycle; load returns `rsp_data=0x1dfe`, `rsp_last=1`, `rsp_err=0`.
- Store burst at 0x03FC, len=3, data 0x1001..0x1004, with `wd_valid` gaps of 2 cycles; then load burst of the same range → four reads 0x1001..0x1004 in order; `rsp_last` only on the 4th.
- Load at 0x03FE with len=3 → single ERR response (`rsp_err=1`, `rsp_data=0`); `we_DM` stays 0 and `addrDM` is unchanged.
- Load burst of 3 with `rsp_ready` held low for 5 cycles on beat 2 → `rsp_data`/`rsp_last` stable while stalled; `addrDM` does not advance; no beat is lost.
- `rst_n` low during W_STROBE of a store to 0x0010 with data 0xa001 → `we_DM=0` the next cycle; no response; `req_ready=1` after reset is released.
- len=0 and len=15 stores → exactly 1 and exactly 16 `we_DM` pulses, with addresses incrementing by 1.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory access controller.
package dm_pkg;

  localparam int DM_AW        = 16;
  localparam int DM_DW        = 16;
  localparam int DM_LENW      = 4;
  localparam int DM_WAITW     = 3;
  localparam int DM_MEM_DEPTH = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    W_ACK,
    R_SETUP,
    R_RESP
  } dm_state_t;

  // End address is computed one bit wider so a burst near 0xFFFF cannot wrap past the check.
  function automatic logic range_err(input logic [DM_AW-1:0]   addr,
                                     input logic [DM_LENW-1:0] len,
                                     input int                 depth);
    logic [DM_AW:0] end_addr;
    end_addr = {1'b0, addr} + {{(DM_AW + 1 - DM_LENW){1'b0}}, len};
    return end_addr > (DM_AW + 1)'(depth - 1);
  endfunction

endpackage

// File: rtl/dm_beat_ctr.sv
// Burst bookkeeping: current word address, beats remaining and the read-wait down-counter.
module dm_beat_ctr
  import dm_pkg::*;
#(
  parameter int RD_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [DM_AW-1:0]   addr_i,
  input  logic [DM_LENW-1:0] len_i,
  input  logic               adv_i,
  input  logic               wait_dec_i,
  output logic [DM_AW-1:0]   cur_addr_o,
  output logic               last_o,
  output logic               wait_done_o
);

  logic [DM_AW-1:0]    addr_q, addr_d;
  logic [DM_LENW-1:0]  rem_q, rem_d;
  logic [DM_WAITW-1:0] wait_q, wait_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    wait_d = wait_q;
    if (load_i) begin
      addr_d = addr_i;
      rem_d  = len_i;
      wait_d = DM_WAITW'(RD_WAIT);
    end else if (adv_i) begin
      addr_d = addr_q + DM_AW'(1);
      rem_d  = rem_q - DM_LENW'(1);
      wait_d = DM_WAITW'(RD_WAIT);
    end else if (wait_dec_i && (wait_q != '0)) begin
      wait_d = wait_q - DM_WAITW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
      wait_q <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      wait_q <= wait_d;
    end
  end

  assign cur_addr_o  = addr_q;
  assign last_o      = (rem_q == '0);
  assign wait_done_o = (wait_q == '0);

endmodule

// File: rtl/dm_access_ctrl.sv
// Initiator for the asynchronous datamem port: sequences setup/strobe/hold around each beat
// of a load or store burst and returns read data or a single store acknowledge.
//
// state    | meaning
// IDLE     | ready for a request; memory port holds its last address/data
// ERR      | burst would run past the end of memory; one error response, no access
// W_SETUP  | address stable, waiting for a store data beat
// W_STROBE | we_DM high for this one cycle
// W_HOLD   | address/data held after the strobe; advance or finish
// W_ACK    | single acknowledge for the whole store burst
// R_SETUP  | address stable, counting down RD_WAIT before sampling outDM
// R_RESP   | read beat presented to the core
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int MEM_DEPTH = DM_MEM_DEPTH,
  parameter int RD_WAIT   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [DM_AW-1:0]   req_addr,
  input  logic [DM_LENW-1:0] req_len,
  input  logic               wd_valid,
  output logic               wd_ready,
  input  logic [DM_DW-1:0]   wd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DM_DW-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               rsp_last,
  output logic               busy,
  output logic               we_DM,
  output logic [DM_AW-1:0]   addrDM,
  output logic [DM_DW-1:0]   dataDM,
  input  logic [DM_DW-1:0]   outDM
);

  dm_state_t        state_q, state_d;
  logic             we_dm_q, we_dm_d;
  logic [DM_DW-1:0] data_dm_q, data_dm_d;
  logic [DM_DW-1:0] rd_data_q, rd_data_d;
  logic             ctr_load, ctr_adv, ctr_wait_dec;
  logic             last_beat, wait_done;
  logic [DM_AW-1:0] cur_addr;

  dm_beat_ctr #(.RD_WAIT(RD_WAIT)) u_beat_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ctr_load),
    .addr_i      (req_addr),
    .len_i       (req_len),
    .adv_i       (ctr_adv),
    .wait_dec_i  (ctr_wait_dec),
    .cur_addr_o  (cur_addr),
    .last_o      (last_beat),
    .wait_done_o (wait_done)
  );

  always_comb begin
    state_d      = state_q;
    we_dm_d      = 1'b0;
    data_dm_d    = data_dm_q;
    rd_data_d    = rd_data_q;
    ctr_load     = 1'b0;
    ctr_adv      = 1'b0;
    ctr_wait_dec = 1'b0;
    req_ready    = 1'b0;
    wd_ready     = 1'b0;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    rsp_last     = 1'b0;
    rsp_data     = '0;
    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so nothing is offered a handshake it cannot get.
        req_ready = rst_n;
        if (req_valid) begin
          if (range_err(req_addr, req_len, MEM_DEPTH)) begin
            state_d = ERR;
          end else begin
            ctr_load = 1'b1;
            state_d  = req_we ? W_SETUP : R_SETUP;
          end
        end
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        rsp_last  = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      W_SETUP: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          data_dm_d = wd_data;
          we_dm_d   = 1'b1;
          state_d   = W_STROBE;
        end
      end
      W_STROBE: state_d = W_HOLD;
      W_HOLD: begin
        if (last_beat) begin
          state_d = W_ACK;
        end else begin
          ctr_adv = 1'b1;
          state_d = W_SETUP;
        end
      end
      W_ACK: begin
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      R_SETUP: begin
        ctr_wait_dec = 1'b1;
        if (wait_done) begin
          rd_data_d = outDM;
          state_d   = R_RESP;
        end
      end
      R_RESP: begin
        rsp_valid = 1'b1;
        rsp_last  = last_beat;
        rsp_data  = rd_data_q;
        if (rsp_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            ctr_adv = 1'b1;
            state_d = R_SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_dm_q   <= 1'b0;
      data_dm_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      we_dm_q   <= we_dm_d;
      data_dm_q <= data_dm_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign we_DM  = we_dm_q;
  assign addrDM = cur_addr;
  assign dataDM = data_dm_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural datamem and a response scoreboard.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [3:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [15:0] wd_data;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_last, busy;
  logic [15:0] rsp_data;
  logic        we_DM;
  logic [15:0] addrDM, dataDM, outDM;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
    logic        last;
  } rsp_t;

  rsp_t exp_q[$];

  always #5 clk = ~clk;

  dm_access_ctrl #(.MEM_DEPTH(1024), .RD_WAIT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .we_DM     (we_DM),
    .addrDM    (addrDM),
    .dataDM    (dataDM),
    .outDM     (outDM)
  );

  // Behavioural asynchronous-read data memory
  logic [15:0] mem [0:1023];
  assign outDM = mem[addrDM[9:0]];
  always @(posedge clk) if (we_DM) mem[addrDM[9:0]] <= dataDM;

  logic        we_prev = 1'b0;
  int          we_pulses = 0;
  int          we_long = 0;
  logic [15:0] wr_addr_q[$];
  always @(posedge clk) begin
    we_prev <= we_DM;
    if (we_DM && !we_prev) begin
      we_pulses <= we_pulses + 1;
      wr_addr_q.push_back(addrDM);
    end
    if (we_DM && we_prev) we_long <= we_long + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [15:0] d, input logic e, input logic l);
    rsp_t r;
    r.data = d;
    r.err  = e;
    r.last = l;
    return r;
  endfunction

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [3:0] len);
    int t;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic feed_wd(input int nbeats, input logic [15:0] base, input int gap);
    int t;
    for (int b = 0; b < nbeats; b++) begin
      wd_valid = 1'b0;
      t = 0;
      while (!wd_ready && t < 100) begin @(negedge clk); t++; end
      if (!wd_ready) chk("wd_ready_timeout", 32'(wd_ready), 32'd1);
      repeat (gap) @(negedge clk);
      wd_valid = 1'b1;
      wd_data  = base + 16'(b);
      @(negedge clk);
    end
    wd_valid = 1'b0;
  endtask

  task automatic collect(input int stall_beat, input int stall_cyc);
    rsp_t        e;
    logic [15:0] d0;
    logic [15:0] a0;
    logic        l0;
    int          t;
    int          beat;
    beat = 0;
    while (exp_q.size() > 0) begin
      t = 0;
      while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
      if (!rsp_valid) begin
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        exp_q.delete();
        return;
      end
      if (beat == stall_beat) begin
        rsp_ready = 1'b0;
        d0 = rsp_data;
        l0 = rsp_last;
        a0 = addrDM;
        repeat (stall_cyc) begin
          @(negedge clk);
          chk("stall_valid", 32'(rsp_valid), 32'd1);
          chk("stall_data", 32'(rsp_data), 32'(d0));
          chk("stall_last", 32'(rsp_last), 32'(l0));
          chk("stall_addr", 32'(addrDM), 32'(a0));
        end
      end
      e = exp_q.pop_front();
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      chk("rsp_last", 32'(rsp_last), 32'(e.last));
      rsp_ready = 1'b1;
      @(negedge clk);
      beat++;
    end
  endtask

  initial begin
    int p0;
    int base_idx;
    logic [15:0] a_before;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wd_valid  = 1'b0;
    wd_data   = '0;
    rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wd_ready", 32'(wd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we_DM", 32'(we_DM), 32'd0);
    chk("rst_addrDM", 32'(addrDM), 32'd0);
    chk("rst_dataDM", 32'(dataDM), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Single store 0x0000 <- 0x1dfe with wd_valid already high; cycle-exact timing
    wd_valid = 1'b1;
    wd_data  = 16'h1dfe;
    @(negedge clk);
    chk("idle_wd_ready", 32'(wd_ready), 32'd0);
    chk("idle_dataDM_ignored", 32'(dataDM), 32'd0);
    p0 = we_pulses;
    do_req(1'b1, 16'h0000, 4'd0);
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_req_ready", 32'(req_ready), 32'd0);
    chk("c1_wd_ready", 32'(wd_ready), 32'd1);
    chk("c1_we_DM", 32'(we_DM), 32'd0);
    @(negedge clk);
    wd_valid = 1'b0;
    chk("c2_we_DM", 32'(we_DM), 32'd1);
    chk("c2_dataDM", 32'(dataDM), 32'h1dfe);
    chk("c2_addrDM", 32'(addrDM), 32'h0000);
    @(negedge clk);
    chk("c3_we_DM", 32'(we_DM), 32'd0);
    chk("c3_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("c4_rsp_valid", 32'(rsp_valid), 32'd1);
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b1));
    collect(-1, 0);
    chk("c5_busy", 32'(busy), 32'd0);
    chk("c5_req_ready", 32'(req_ready), 32'd1);
    chk("single_store_pulses", 32'(we_pulses - p0), 32'd1);
    chk("single_store_pulse_len", 32'(we_long), 32'd0);

    // Single load 0x0000, response in cycle 2+RD_WAIT
    do_req(1'b0, 16'h0000, 4'd0);
    chk("ld_c1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ld_c1_we_DM", 32'(we_DM), 32'd0);
    @(negedge clk);
    chk("ld_c2_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("ld_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    exp_q.push_back(mk(16'h1dfe, 1'b0, 1'b1));
    collect(-1, 0);

    // Store burst at the top of memory with 2-cycle data gaps, then read it back
    p0 = we_pulses;
    do_req(1'b1, 16'h03FC, 4'd3);
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b1));
    feed_wd(4, 16'h1001, 2);
    collect(-1, 0);
    chk("burst_store_pulses", 32'(we_pulses - p0), 32'd4);
    do_req(1'b0, 16'h03FC, 4'd3);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(16'h1001 + 16'(i), 1'b0, i == 3));
    collect(-1, 0);

    // Range error: 0x03FE + 3 runs past the last word
    p0 = we_pulses;
    a_before = addrDM;
    do_req(1'b0, 16'h03FE, 4'd3);
    chk("err_busy", 32'(busy), 32'd1);
    exp_q.push_back(mk(16'h0000, 1'b1, 1'b1));
    collect(-1, 0);
    chk("err_no_we", 32'(we_pulses - p0), 32'd0);
    chk("err_addr_unchanged", 32'(addrDM), 32'(a_before));

    // Load burst of 3 with the response stalled 5 cycles on beat 2
    do_req(1'b0, 16'h03FC, 4'd2);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(16'h1001 + 16'(i), 1'b0, i == 2));
    collect(1, 5);

    // len=0 store: one pulse
    p0 = we_pulses;
    do_req(1'b1, 16'h0020, 4'd0);
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b1));
    feed_wd(1, 16'h2222, 0);
    collect(-1, 0);
    chk("len0_pulses", 32'(we_pulses - p0), 32'd1);
    chk("len0_mem", 32'(mem[10'h020]), 32'h2222);

    // len=15 store: sixteen pulses at consecutive addresses
    p0 = we_pulses;
    base_idx = wr_addr_q.size();
    do_req(1'b1, 16'h0100, 4'd15);
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b1));
    feed_wd(16, 16'h3000, 0);
    collect(-1, 0);
    chk("len15_pulses", 32'(we_pulses - p0), 32'd16);
    if (wr_addr_q.size() >= base_idx + 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("len15_addr", 32'(wr_addr_q[base_idx + i]), 32'h0100 + 32'(i));
        chk("len15_mem", 32'(mem[10'h100 + 10'(i)]), 32'h3000 + 32'(i));
      end
    end else begin
      chk("len15_addr_count", 32'(wr_addr_q.size() - base_idx), 32'd16);
    end
    chk("all_pulses_one_cycle", 32'(we_long), 32'd0);

    // Reset during W_STROBE drops the burst
    do_req(1'b1, 16'h0010, 4'd0);
    wd_valid = 1'b1;
    wd_data  = 16'ha001;
    @(negedge clk);
    wd_valid = 1'b0;
    chk("rstmid_we_high", 32'(we_DM), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_we_low", 32'(we_DM), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rstmid_ready", 32'(req_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
